// File: rtl/sprite_dma_pkg.sv
// Shared types and default widths for the sprite list DMA engine.
package sprite_dma_pkg;
   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      COPY,
      DRAIN,
      CLEAR,
      FINISH
   } dma_state_t;
endpackage

// File: rtl/dma_skid_reg.sv
// One-entry address+data holding register that parks a read result while the
// destination port is contended.
module dma_skid_reg #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              unload,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              full,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);
   always_ff @(posedge clock) begin
      if (reset) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         addr <= load_addr;
         data <= load_data;
      end else if (unload) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/sprite_dma.sv
// Sprite RAM -> sprite buffer bulk copy engine.
// Optional macro SPRITE_DMA_CLEAR_EN zero-fills the buffer tail after the copy.
module sprite_dma
   import sprite_dma_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   count,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] src_q,
   output logic              dst_wren,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [DATA_W-1:0] dst_data
);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

   dma_state_t        state_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   remaining_q;
   logic [ADDR_W-1:0] src_addr_q;
   logic              pipe_valid_q;
   logic [ADDR_W-1:0] pipe_addr_q;
   logic              skid_full;
   logic [ADDR_W-1:0] skid_addr;
   logic [DATA_W-1:0] skid_data;
   logic              issue;
   logic              pipe_write;
   logic              skid_unload;
   logic              drain_empty;
`ifdef SPRITE_DMA_CLEAR_EN
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [ADDR_W:0]   clr_rem_q;
   logic              clr_write;
   assign clr_write = (state_q == CLEAR) && !hold;
`endif

   // Skid and pipeline are never valid together: a skid load implies hold, which
   // blocked the read that would otherwise refill the pipeline.
   assign issue       = (state_q == COPY) && !hold && !skid_full;
   assign pipe_write  = pipe_valid_q && !hold;
   assign skid_unload = skid_full && !hold;
   assign drain_empty = !hold || !(pipe_valid_q || skid_full);
   assign src_addr    = issue ? rd_ptr_q : src_addr_q;

   dma_skid_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .load      (pipe_valid_q && hold),
      .unload    (skid_unload),
      .load_addr (pipe_addr_q),
      .load_data (src_q),
      .full      (skid_full),
      .addr      (skid_addr),
      .data      (skid_data)
   );

   always_comb begin
      dst_wren = 1'b0;
      dst_addr = '0;
      dst_data = '0;
      if (skid_unload) begin
         dst_wren = 1'b1;
         dst_addr = skid_addr;
         dst_data = skid_data;
      end else if (pipe_write) begin
         dst_wren = 1'b1;
         dst_addr = pipe_addr_q;
         dst_data = src_q;
`ifdef SPRITE_DMA_CLEAR_EN
      end else if (clr_write) begin
         dst_wren = 1'b1;
         dst_addr = clr_ptr_q;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         rd_ptr_q     <= '0;
         remaining_q  <= '0;
         src_addr_q   <= '0;
         pipe_valid_q <= 1'b0;
         pipe_addr_q  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef SPRITE_DMA_CLEAR_EN
         clr_ptr_q    <= '0;
         clr_rem_q    <= '0;
`endif
      end else begin
         done         <= 1'b0;
         pipe_valid_q <= issue;
         if (issue) begin
            pipe_addr_q <= rd_ptr_q;
            src_addr_q  <= rd_ptr_q;
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            remaining_q <= remaining_q - CNT_ONE;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  remaining_q <= count;
                  rd_ptr_q    <= '0;
                  busy        <= 1'b1;
                  state_q     <= (count == '0) ? DRAIN : COPY;
`ifdef SPRITE_DMA_CLEAR_EN
                  clr_ptr_q   <= count[ADDR_W-1:0];
                  clr_rem_q   <= DEPTH - count;
`endif
               end
            end
            COPY: begin
               if (issue && remaining_q == CNT_ONE) state_q <= DRAIN;
            end
            DRAIN: begin
               if (drain_empty) begin
`ifdef SPRITE_DMA_CLEAR_EN
                  if (clr_rem_q != '0) begin
                     state_q <= CLEAR;
                  end else begin
                     state_q <= FINISH;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
`else
                  state_q <= FINISH;
                  busy    <= 1'b0;
                  done    <= 1'b1;
`endif
               end
            end
`ifdef SPRITE_DMA_CLEAR_EN
            CLEAR: begin
               if (!hold) begin
                  clr_ptr_q <= clr_ptr_q + PTR_ONE;
                  clr_rem_q <= clr_rem_q - CNT_ONE;
                  if (clr_rem_q == CNT_ONE) begin
                     state_q <= FINISH;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
`endif
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_dma.sv
// Randomized self-checking bench for sprite_dma; expected write streams come
// from a list model of the copy (plus zero tail when SPRITE_DMA_CLEAR_EN is set).
module tb_sprite_dma;
   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   count = '0;
   logic          hold  = 1'b0;
   logic          busy, done, dst_wren;
   logic [AW-1:0] src_addr, dst_addr;
   logic [DW-1:0] src_q, dst_data;

   logic [DW-1:0] src_mem [DEPTH];

   int n_cmp = 0;
   int n_err = 0;
   int wr_a[$], wr_d[$], wr_c[$], done_c[$];
   int exp_a[$], exp_d[$];
   int busy_n, busy_first, busy_last, hold_viol;
   bit timed_out;

   sprite_dma #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .count    (count),
      .hold     (hold),
      .busy     (busy),
      .done     (done),
      .src_addr (src_addr),
      .src_q    (src_q),
      .dst_wren (dst_wren),
      .dst_addr (dst_addr),
      .dst_data (dst_data)
   );

   always #5 clock = ~clock;

   // Source RAM: registered read, one cycle latency.
   always @(posedge clock) src_q <= src_mem[src_addr];

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) src_mem[i] = DW'($urandom);
   endtask

   // Reference: words 0..n-1 copied in order, then optional zero fill of the tail.
   task automatic build_expected(input int n);
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < n; i++) begin
         exp_a.push_back(i);
         exp_d.push_back(int'(src_mem[i]));
      end
`ifdef SPRITE_DMA_CLEAR_EN
      for (int i = n; i < DEPTH; i++) begin
         exp_a.push_back(i);
         exp_d.push_back(0);
      end
`endif
   endtask

   // Drives one transfer (start at relative cycle 0) and records what the DUT does.
   // hold_kind: 0 none, 1 cycles 2..4, 2 random.
   task automatic run_xfer(input int n, input int hold_kind, input int rst_at,
                           input int s1, input int s2, input int max_rel);
      wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
      busy_n = 0; busy_first = -1; busy_last = -1; hold_viol = 0;
      for (int rel = 0; rel < max_rel; rel++) begin
         @(posedge clock);
         #1;
         start = (rel == 0) || (rel == s1) || (rel == s2);
         count = (rel == 0) ? n[AW:0] : (AW+1)'($urandom_range(1, 20));
         reset = (rel == rst_at);
         case (hold_kind)
            1:       hold = (rel >= 2) && (rel <= 4);
            2:       hold = ($urandom_range(0, 2) == 0);
            default: hold = 1'b0;
         endcase
         @(negedge clock);
         if (dst_wren) begin
            wr_a.push_back(int'(dst_addr));
            wr_d.push_back(int'(dst_data));
            wr_c.push_back(rel);
            if (hold) hold_viol++;
         end
         if (done) done_c.push_back(rel);
         if (busy) begin
            if (busy_n == 0) busy_first = rel;
            busy_last = rel;
            busy_n++;
         end
         if (done_c.size() > 0 && rel >= done_c[0] + 4) break;
         if (rst_at >= 0 && rel >= rst_at + 6) break;
      end
      start = 1'b0;
      reset = 1'b0;
      hold  = 1'b0;
      timed_out = (rst_at < 0) && (done_c.size() == 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({busy, done, dst_wren} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got busy/done/wren=%b%b%b expected 000", busy, done, dst_wren);
      end
      n_cmp++;
      if (src_addr !== '0 || dst_addr !== '0 || dst_data !== '0) begin
         n_err++;
         $display("FAIL reset_buses: got src_addr=%0d dst_addr=%0d dst_data=%0h expected 0/0/0",
                  src_addr, dst_addr, dst_data);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < DEPTH; i++) src_mem[i] = DW'(32'hA000 + i);
      build_expected(4);
      run_xfer(4, 0, -1, -1, -1, 3000);
      n_cmp++;
      if (timed_out) begin
         n_err++;
         $display("FAIL basic_timeout: got no done expected done");
      end
      n_cmp++;
      if (wr_a.size() != exp_a.size()) begin
         n_err++;
         $display("FAIL basic_nwrites: got %0d expected %0d", wr_a.size(), exp_a.size());
      end
      for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
         n_cmp++;
         if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k] || wr_c[k] != k + 2) begin
            n_err++;
            $display("FAIL basic_write[%0d]: got addr=%0d data=%0h cycle=%0d expected addr=%0d data=%0h cycle=%0d",
                     k, wr_a[k], wr_d[k], wr_c[k], exp_a[k], exp_d[k], k + 2);
         end
      end
      n_cmp++;
      if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != exp_a.size() + 2)) begin
         n_err++;
         $display("FAIL basic_done: got %0d pulses first at %0d expected 1 pulse at %0d",
                  done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, exp_a.size() + 2);
      end
      n_cmp++;
      if (busy_first != 1 || busy_n != exp_a.size() + 1) begin
         n_err++;
         $display("FAIL basic_busy: got first=%0d cycles=%0d expected first=1 cycles=%0d",
                  busy_first, busy_n, exp_a.size() + 1);
      end
   endtask

   task automatic test_hold_stall();
      fill_random();
      build_expected(3);
      run_xfer(3, 1, -1, -1, -1, 3000);
      n_cmp++;
      if (hold_viol != 0) begin
         n_err++;
         $display("FAIL hold_wren: got %0d writes under hold expected 0", hold_viol);
      end
      n_cmp++;
      if (wr_c.size() == 0 || wr_c[0] != 5) begin
         n_err++;
         $display("FAIL hold_first_write: got cycle %0d expected 5", (wr_c.size() > 0) ? wr_c[0] : -1);
      end
      n_cmp++;
      if (wr_a.size() != exp_a.size()) begin
         n_err++;
         $display("FAIL hold_nwrites: got %0d expected %0d", wr_a.size(), exp_a.size());
      end
      for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
         n_cmp++;
         if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k]) begin
            n_err++;
            $display("FAIL hold_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                     k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
         end
      end
      n_cmp++;
      if (done_c.size() != 1) begin
         n_err++;
         $display("FAIL hold_done: got %0d pulses expected 1", done_c.size());
      end
   endtask

   task automatic test_random_hold();
      for (int it = 0; it < 6; it++) begin
         int n;
         n = int'($urandom_range(1, 40));
         fill_random();
         build_expected(n);
         run_xfer(n, 2, -1, -1, -1, 5000);
         n_cmp++;
         if (hold_viol != 0) begin
            n_err++;
            $display("FAIL rand_wren_hold[%0d]: got %0d writes under hold expected 0", it, hold_viol);
         end
         n_cmp++;
         if (wr_a.size() != exp_a.size()) begin
            n_err++;
            $display("FAIL rand_nwrites[%0d]: got %0d expected %0d (n=%0d)", it, wr_a.size(), exp_a.size(), n);
         end
         for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
            n_cmp++;
            if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k]) begin
               n_err++;
               $display("FAIL rand_write[%0d][%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                        it, k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
            end
         end
         n_cmp++;
         if (done_c.size() != 1 || busy_first != 1 || busy_n != done_c[0] - 1) begin
            n_err++;
            $display("FAIL rand_done_busy[%0d]: got pulses=%0d busy_first=%0d busy_cycles=%0d expected 1 pulse, busy 1..done-1",
                     it, done_c.size(), busy_first, busy_n);
         end
      end
   endtask

   task automatic test_zero_full();
      fill_random();
      build_expected(0);
      run_xfer(0, 0, -1, -1, -1, 3000);
      n_cmp++;
      if (wr_a.size() != exp_a.size()) begin
         n_err++;
         $display("FAIL zero_nwrites: got %0d expected %0d", wr_a.size(), exp_a.size());
      end
      n_cmp++;
      if (done_c.size() != 1 || done_c[0] != exp_a.size() + 2 || busy_n != exp_a.size() + 1) begin
         n_err++;
         $display("FAIL zero_done: got pulses=%0d at %0d busy_cycles=%0d expected 1 at %0d busy_cycles=%0d",
                  done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, busy_n, exp_a.size() + 2, exp_a.size() + 1);
      end
      build_expected(DEPTH);
      run_xfer(DEPTH, 0, -1, -1, -1, 3000);
      n_cmp++;
      if (wr_a.size() != DEPTH || wr_a[wr_a.size() - 1] != DEPTH - 1) begin
         n_err++;
         $display("FAIL full_nwrites: got %0d writes expected %0d ending at %0d",
                  wr_a.size(), DEPTH, DEPTH - 1);
      end
      for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
         n_cmp++;
         if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k] || wr_c[k] != k + 2) begin
            n_err++;
            $display("FAIL full_write[%0d]: got addr=%0d data=%0h cycle=%0d expected addr=%0d data=%0h cycle=%0d",
                     k, wr_a[k], wr_d[k], wr_c[k], exp_a[k], exp_d[k], k + 2);
         end
      end
      n_cmp++;
      if (done_c.size() != 1 || done_c[0] != DEPTH + 2) begin
         n_err++;
         $display("FAIL full_done: got pulses=%0d at %0d expected 1 at %0d",
                  done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, DEPTH + 2);
      end
   endtask

   task automatic test_reset_mid();
      fill_random();
      run_xfer(8, 0, 4, -1, -1, 100);
      n_cmp++;
      if (wr_a.size() != 3) begin
         n_err++;
         $display("FAIL rstmid_nwrites: got %0d expected 3", wr_a.size());
      end
      for (int k = 0; k < wr_a.size() && k < 3; k++) begin
         n_cmp++;
         if (wr_a[k] != k || wr_d[k] != int'(src_mem[k]) || wr_c[k] != k + 2) begin
            n_err++;
            $display("FAIL rstmid_write[%0d]: got addr=%0d data=%0h cycle=%0d expected addr=%0d data=%0h cycle=%0d",
                     k, wr_a[k], wr_d[k], wr_c[k], k, src_mem[k], k + 2);
         end
      end
      n_cmp++;
      if (done_c.size() != 0 || busy_last != 4) begin
         n_err++;
         $display("FAIL rstmid_state: got done pulses=%0d last busy=%0d expected 0 pulses last busy=4",
                  done_c.size(), busy_last);
      end
      build_expected(2);
      run_xfer(2, 0, -1, -1, -1, 3000);
      n_cmp++;
      if (wr_a.size() != exp_a.size() || done_c.size() != 1) begin
         n_err++;
         $display("FAIL rstmid_restart: got %0d writes %0d done expected %0d writes 1 done",
                  wr_a.size(), done_c.size(), exp_a.size());
      end
      for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
         n_cmp++;
         if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k]) begin
            n_err++;
            $display("FAIL rstmid_restart_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                     k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_start_ignored();
      fill_random();
      build_expected(6);
      // Stray starts mid-copy and in the FINISH cycle.
      run_xfer(6, 0, -1, 3, exp_a.size() + 2, 3000);
      n_cmp++;
      if (wr_a.size() != exp_a.size()) begin
         n_err++;
         $display("FAIL startign_nwrites: got %0d expected %0d", wr_a.size(), exp_a.size());
      end
      for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
         n_cmp++;
         if (wr_a[k] != exp_a[k] || wr_d[k] != exp_d[k]) begin
            n_err++;
            $display("FAIL startign_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                     k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
         end
      end
      n_cmp++;
      if (done_c.size() != 1 || done_c[0] != exp_a.size() + 2 || busy_last != exp_a.size() + 1) begin
         n_err++;
         $display("FAIL startign_restart: got pulses=%0d done=%0d last busy=%0d expected 1 pulse at %0d last busy %0d",
                  done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, busy_last, exp_a.size() + 2, exp_a.size() + 1);
      end
   endtask

   initial begin
      fill_random();
      test_reset();
      test_basic();
      test_hold_stall();
      test_random_hold();
      test_zero_full();
      test_reset_mid();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
